luma_filter_mac: RTL and testbench

Sequential 8-tap HEVC luma half-sample interpolation actor, directly upstream of the >>11 normalising shifter in the prediction path. It drains eight consecutive samples from one of FLUX input FIFO lanes and multiply-accumulates them against the fixed half-pel coefficients. It then writes one unnormalised sum into the shared output FIFO, which the shifter consumes. Lane arbitration is fixed-priority per result, and a lane stays locked until its 8-sample group completes.

---
 rtl/hevc_filter_pkg.sv | 28 ++
 rtl/flux_priority_sel.sv | 25 ++
 rtl/luma_filter_mac.sv | 177 +++++++++++++++++
 tb/tb_luma_filter_mac.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hevc_filter_pkg.sv
// Shared definitions for the HEVC interpolation filter actors.
// Holds the tap count, the coefficient type, the luma half-sample
// coefficient table, the rounding seed and the MAC state encoding.
package hevc_filter_pkg;

    localparam int TAPS = 8;

    typedef logic signed [7:0] coeff_t;

    // Half-pel luma taps; they sum to 64, so a flat input of v yields 64*v.
    localparam coeff_t LUMA_HALF_COEFF [TAPS] = '{
        -8'sd1, 8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1
    };

    // Half of the downstream >>11 step, used as the accumulator seed when rounding.
    localparam int ROUND_OFFSET = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } luma_state_e;

    function automatic coeff_t tap_coeff(input logic [2:0] k);
        return LUMA_HALF_COEFF[k];
    endfunction

endpackage

// File: rtl/flux_priority_sel.sv
// Fixed-priority lane selector shared by the filter actors.
// Ports:
//   empty [FLUX]  per-lane FIFO empty flags
//   valid         at least one lane is non-empty
//   idx           lowest-numbered non-empty lane (0 when none)
module flux_priority_sel #(
    parameter int FLUX  = 2,
    parameter int IDX_W = 1
) (
    input  logic [FLUX-1:0]  empty,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top lane downwards so the lowest non-empty index is the last one kept.
    always_comb begin
        valid = 1'b0;
        idx   = {IDX_W{1'b0}};
        for (int i = FLUX - 1; i >= 0; i--) begin
            valid = valid | ~empty[i];
            idx   = empty[i] ? idx : IDX_W'(i);
        end
    end

endmodule

// File: rtl/luma_filter_mac.sv
// Sequential 8-tap HEVC luma half-sample MAC actor.
// Locks onto the lowest non-empty input lane, accumulates eight samples
// against the half-pel taps and writes one unnormalised sum to the result
// FIFO feeding the >>11 shifter.
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   read_port_in_pel_empty/read/dout  FLUX first-word-fall-through sample FIFOs
//   write_port_out_pel_full/write/din result FIFO
// Build option: define LUMA_FILTER_ROUND_EN to seed the accumulator with
// ROUND_OFFSET so the downstream shift rounds to nearest instead of truncating.
module luma_filter_mac
    import hevc_filter_pkg::*;
#(
    parameter int FLUX       = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [FLUX-1:0]                      read_port_in_pel_empty,
    output logic [FLUX-1:0]                      read_port_in_pel_read,
    input  logic [FLUX-1:0][DATA_WIDTH-1:0]      read_port_in_pel_dout,
    input  logic                                 write_port_out_pel_full,
    output logic                                 write_port_out_pel_write,
    output logic [DATA_WIDTH-1:0]                write_port_out_pel_din
);

    localparam int TAG_W = (FLUX > 1) ? $clog2(FLUX) : 1;

`ifdef LUMA_FILTER_ROUND_EN
    localparam logic [DATA_WIDTH-1:0] ACC_SEED = DATA_WIDTH'(ROUND_OFFSET);
`else
    localparam logic [DATA_WIDTH-1:0] ACC_SEED = {DATA_WIDTH{1'b0}};
`endif

    luma_state_e              state_r;
    luma_state_e              state_nxt_s;
    logic [TAG_W-1:0]         tag_r;
    logic [2:0]               k_r;
    logic [DATA_WIDTH-1:0]    acc_r;

    logic                     sel_valid_s;
    logic [TAG_W-1:0]         sel_idx_s;
    logic                     lane_ready_s;
    logic [TAG_W-1:0]         lane_s;
    logic [2:0]               tap_s;
    logic signed [DATA_WIDTH-1:0] coeff_ext_s;
    logic signed [DATA_WIDTH-1:0] sample_s;
    logic [DATA_WIDTH-1:0]    product_s;
    logic [DATA_WIDTH-1:0]    base_s;

    flux_priority_sel #(
        .FLUX  (FLUX),
        .IDX_W (TAG_W)
    ) u_sel (
        .empty (read_port_in_pel_empty),
        .valid (sel_valid_s),
        .idx   (sel_idx_s)
    );

    // In IDLE the selector picks the lane and tap 0 is applied on a fresh seed;
    // afterwards the locked lane and running accumulator are used.
    assign lane_ready_s = ~read_port_in_pel_empty[tag_r];
    assign lane_s       = (state_r == ST_IDLE) ? sel_idx_s : tag_r;
    assign tap_s        = (state_r == ST_IDLE) ? 3'd0 : k_r;
    assign base_s       = (state_r == ST_IDLE) ? ACC_SEED : acc_r;
    assign coeff_ext_s  = DATA_WIDTH'(tap_coeff(tap_s));
    assign sample_s     = $signed(read_port_in_pel_dout[lane_s]);
    // Signed product truncated to DATA_WIDTH: wraps modulo 2^DATA_WIDTH.
    assign product_s    = coeff_ext_s * sample_s;

    assign write_port_out_pel_din = acc_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: lock on a lane, count eight reads, wait for room to write.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sel_valid_s) begin
                    state_nxt_s = ST_ACC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (lane_ready_s && (k_r == 3'd7)) begin
                    state_nxt_s = ST_OUT;
                end else begin
                    state_nxt_s = ST_ACC;
                end
            end
            ST_OUT: begin
                if (!write_port_out_pel_full) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FIFO handshakes; suppressed during reset so nothing is consumed or emitted then.
    always_comb begin
        read_port_in_pel_read    = {FLUX{1'b0}};
        write_port_out_pel_write = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sel_valid_s && !rst) begin
                    read_port_in_pel_read[sel_idx_s] = 1'b1;
                end else begin
                    read_port_in_pel_read = {FLUX{1'b0}};
                end
            end
            ST_ACC: begin
                if (lane_ready_s && !rst) begin
                    read_port_in_pel_read[tag_r] = 1'b1;
                end else begin
                    read_port_in_pel_read = {FLUX{1'b0}};
                end
            end
            ST_OUT: begin
                write_port_out_pel_write = ~write_port_out_pel_full & ~rst;
            end
            default: begin
                read_port_in_pel_read    = {FLUX{1'b0}};
                write_port_out_pel_write = 1'b0;
            end
        endcase
    end

    // Datapath: lane tag, tap index and accumulator advance only on a consumed sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_r <= {TAG_W{1'b0}};
            k_r   <= 3'd0;
            acc_r <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sel_valid_s) begin
                        tag_r <= sel_idx_s;
                        k_r   <= 3'd1;
                        acc_r <= base_s + product_s;
                    end else begin
                        tag_r <= tag_r;
                        k_r   <= k_r;
                        acc_r <= acc_r;
                    end
                end
                ST_ACC: begin
                    if (lane_ready_s) begin
                        k_r   <= k_r + 3'd1;
                        acc_r <= base_s + product_s;
                    end else begin
                        k_r   <= k_r;
                        acc_r <= acc_r;
                    end
                end
                default: begin
                    tag_r <= tag_r;
                    k_r   <= k_r;
                    acc_r <= acc_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_luma_filter_mac.sv
// Directed self-checking bench for luma_filter_mac.
// Models the input FIFOs as queues; expected sums are hand-computed.
module tb_luma_filter_mac;

`ifdef LUMA_FILTER_ROUND_EN
    localparam int SEED = 1024;
`else
    localparam int SEED = 0;
`endif

    logic             clk;
    logic             rst;
    logic [1:0]       empty_s;
    logic [1:0]       rd_s;
    logic [1:0][31:0] dout_s;
    logic             full_s;
    logic             wr_s;
    logic [31:0]      din_s;

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rd_cnt0 = 0;
    int rd_cnt1 = 0;
    int wr_cnt = 0;
    int viol = 0;
    int first_rd_cyc = -1;
    int first_rd_lane = -1;
    int wr_cyc = -1;
    int w1;
    logic [1:0]  last_rd;
    logic        last_wr;
    logic [31:0] last_din;
    logic [31:0] res;
    logic [31:0] snap;
    logic [31:0] tmp;

    luma_filter_mac #(.FLUX(2), .DATA_WIDTH(32)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .read_port_in_pel_empty   (empty_s),
        .read_port_in_pel_read    (rd_s),
        .read_port_in_pel_dout    (dout_s),
        .write_port_out_pel_full  (full_s),
        .write_port_out_pel_write (wr_s),
        .write_port_out_pel_din   (din_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic refresh();
        empty_s[0] = (q0.size() == 0);
        empty_s[1] = (q1.size() == 0);
        dout_s[0]  = (q0.size() != 0) ? q0[0] : 32'd0;
        dout_s[1]  = (q1.size() != 0) ? q1[0] : 32'd0;
    endtask

    task automatic push_n(input int lane, input int n, input logic [31:0] v);
        for (int i = 0; i < n; i++) begin
            if (lane == 0) q0.push_back(v);
            else           q1.push_back(v);
        end
        refresh();
    endtask

    // One clock: sample handshakes at negedge, then pop what was consumed.
    task automatic step();
        @(negedge clk);
        last_rd  = rd_s;
        last_wr  = wr_s;
        last_din = din_s;
        if (rd_s[0]) rd_cnt0++;
        if (rd_s[1]) rd_cnt1++;
        if (rd_s[0] && rd_s[1]) viol++;
        if (wr_s && (rd_s != 2'b00)) viol++;
        if ((rd_s != 2'b00) && (first_rd_cyc < 0)) begin
            first_rd_cyc  = cyc;
            first_rd_lane = rd_s[1] ? 1 : 0;
        end
        if (wr_s) begin
            wr_cyc = cyc;
            wr_cnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (last_rd[0]) tmp = q0.pop_front();
        if (last_rd[1]) tmp = q1.pop_front();
        refresh();
    endtask

    task automatic run_until_write(input int max_cyc, output logic [31:0] d);
        int start;
        int i;
        start = wr_cnt;
        i = 0;
        while ((wr_cnt == start) && (i < max_cyc)) begin
            step();
            i++;
        end
        check("write_seen", 32'(wr_cnt - start), 32'd1);
        d = last_din;
    endtask

    task automatic new_group();
        first_rd_cyc  = -1;
        first_rd_lane = -1;
    endtask

    initial begin
        rst    = 1'b1;
        full_s = 1'b0;
        refresh();

        // Reset state
        step();
        step();
        rst = 1'b0;
        step();
        check("rst_read", 32'(last_rd), 32'd0);
        check("rst_write", 32'(last_wr), 32'd0);
        check("rst_din", last_din, 32'd0);

        // Flat 100: sum 6400, 8 reads, write 8 cycles after first read
        rd_cnt0 = 0;
        new_group();
        push_n(0, 8, 32'd100);
        run_until_write(30, res);
        check("flat100_din", res, 32'(6400 + SEED));
        check("flat100_rd0", 32'(rd_cnt0), 32'd8);
        check("flat100_lat", 32'(wr_cyc - first_rd_cyc), 32'd8);

        // Back-to-back groups: 9 cycles per result
        push_n(0, 16, 32'd2);
        run_until_write(30, res);
        check("b2b_din0", res, 32'(128 + SEED));
        w1 = wr_cyc;
        run_until_write(30, res);
        check("b2b_din1", res, 32'(128 + SEED));
        check("b2b_period", 32'(wr_cyc - w1), 32'd9);

        // Center-weighted pattern: 255*(40+40) = 20400
        push_n(0, 3, 32'd0);
        push_n(0, 2, 32'd255);
        push_n(0, 3, 32'd0);
        run_until_write(30, res);
        check("pattern_din", res, 32'(20400 + SEED));

        // Negative input
        push_n(0, 8, -32'sd100);
        run_until_write(30, res);
        check("neg100_din", res, 32'(-6400 + SEED));

        // Lane 1 locked at k=4 while lane 0 fills
        rd_cnt0 = 0;
        push_n(1, 8, 32'd10);
        repeat (4) step();
        push_n(0, 8, 32'd100);
        run_until_write(30, res);
        check("lock_l1_din", res, 32'(640 + SEED));
        check("lock_no_rd0", 32'(rd_cnt0), 32'd0);
        run_until_write(30, res);
        check("lock_l0_din", res, 32'(6400 + SEED));
        check("lock_l0_rd0", 32'(rd_cnt0), 32'd8);

        // Simultaneous lanes: lane 0 wins
        new_group();
        push_n(1, 8, 32'd1);
        push_n(0, 8, 32'd2);
        run_until_write(30, res);
        check("prio_lane", 32'(first_rd_lane), 32'd0);
        check("prio_din0", res, 32'(128 + SEED));
        run_until_write(30, res);
        check("prio_din1", res, 32'(64 + SEED));

        // Output stall: full held 5 cycles in OUT
        full_s = 1'b1;
        push_n(0, 8, 32'd3);
        repeat (8) step();
        push_n(1, 8, 32'd5);
        rd_cnt0 = 0;
        rd_cnt1 = 0;
        w1 = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_din", last_din, 32'(192 + SEED));
            check("stall_wr", 32'(last_wr), 32'd0);
        end
        check("stall_reads", 32'(rd_cnt0 + rd_cnt1), 32'd0);
        check("stall_wcnt", 32'(wr_cnt - w1), 32'd0);
        full_s = 1'b0;
        step();
        check("unstall_wr", 32'(last_wr), 32'd1);
        check("unstall_din", last_din, 32'(192 + SEED));
        run_until_write(30, res);
        check("after_stall_l1", res, 32'(320 + SEED));

        // Input stall after 3 samples: acc = 7*(-1+4-11) = -56
        push_n(0, 3, 32'd7);
        repeat (4) step();
        snap = last_din;
        check("istall_partial", snap, 32'(-56 + SEED));
        rd_cnt0 = 0;
        repeat (3) step();
        check("istall_hold", last_din, snap);
        check("istall_no_rd", 32'(rd_cnt0), 32'd0);
        push_n(0, 5, 32'd7);
        run_until_write(30, res);
        check("istall_din", res, 32'(448 + SEED));

        // Reset mid-group after 5 samples
        push_n(0, 8, 32'd9);
        repeat (5) step();
        rst = 1'b1;
        step();
        check("midrst_rd", 32'(last_rd), 32'd0);
        check("midrst_wr", 32'(last_wr), 32'd0);
        rst = 1'b0;
        q0.delete();
        refresh();
        step();
        check("postrst_din", last_din, 32'd0);
        check("postrst_rd", 32'(last_rd), 32'd0);
        check("postrst_wr", 32'(last_wr), 32'd0);
        push_n(0, 8, 32'd11);
        run_until_write(30, res);
        check("postrst_sum", res, 32'(704 + SEED));

        check("handshake_excl", 32'(viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
